// File: rtl/sc_frog_pointreg.sv
// Frog position register for the 8x8 crossing game: button-driven moves, hit/nest holds,
// lives and nest bookkeeping, and the per-row bitmap fed to the board comparator.
//
// state     | meaning
// ----------+------------------------------------------------------------
// PLAY      | frog movable by buttons; lose/nest flags are watched
// HIT       | collision: frog frozen at hit spot for HOLD_CYCLES cycles
// NESTED    | frog reached row 7 nest: frozen there for HOLD_CYCLES cycles
// GAMEOVER  | no lives left; bitmap blank until reset
module sc_frog_pointreg #(
    parameter int DATAWIDTH_BUS = 8,
    parameter int START_COL     = 3,
    parameter int LIVES         = 3,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int HOLD_WIDTH    = 26
) (
    input  logic                     SC_FROGPOINT_CLOCK_50,
    input  logic                     SC_FROGPOINT_RESET_InLow,
    input  logic                     SC_FROGPOINT_Up_InLow,
    input  logic                     SC_FROGPOINT_Down_InLow,
    input  logic                     SC_FROGPOINT_Left_InLow,
    input  logic                     SC_FROGPOINT_Right_InLow,
    input  logic                     SC_FROGPOINT_Lose_InHigh,
    input  logic                     SC_FROGPOINT_Nest_InHigh,
    output logic [DATAWIDTH_BUS-1:0] SC_FROGPOINT_POINTREG_0,
    output logic [DATAWIDTH_BUS-1:0] SC_FROGPOINT_POINTREG_1,
    output logic [DATAWIDTH_BUS-1:0] SC_FROGPOINT_POINTREG_2,
    output logic [DATAWIDTH_BUS-1:0] SC_FROGPOINT_POINTREG_3,
    output logic [DATAWIDTH_BUS-1:0] SC_FROGPOINT_POINTREG_4,
    output logic [DATAWIDTH_BUS-1:0] SC_FROGPOINT_POINTREG_5,
    output logic [DATAWIDTH_BUS-1:0] SC_FROGPOINT_POINTREG_6,
    output logic [DATAWIDTH_BUS-1:0] SC_FROGPOINT_POINTREG_7,
    output logic [1:0]               SC_FROGPOINT_Lives_Out,
    output logic [3:0]               SC_FROGPOINT_NestCount_Out,
    output logic                     SC_FROGPOINT_GameOver_OutHigh
);

    localparam int CW = $clog2(DATAWIDTH_BUS);
    localparam logic [CW-1:0]         POS_MAX   = CW'(DATAWIDTH_BUS - 1);
    localparam logic [CW-1:0]         SPAWN_COL = CW'(START_COL);
    localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {ST_PLAY, ST_HIT, ST_NESTED, ST_GAMEOVER} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         row_q, row_d, col_q, col_d;
    logic [1:0]            lives_q, lives_d;
    logic [3:0]            nest_q, nest_d;
    logic [HOLD_WIDTH-1:0] hold_q, hold_d;

    // button order: [0]=up [1]=down [2]=left [3]=right
    logic [3:0] btn_raw, btn_s1, btn_s2, btn_s3, press;
    logic       hold_done;

    assign btn_raw = {SC_FROGPOINT_Right_InLow, SC_FROGPOINT_Left_InLow,
                      SC_FROGPOINT_Down_InLow, SC_FROGPOINT_Up_InLow};
    assign press     = ~btn_s2 & btn_s3;
    assign hold_done = (hold_q == HOLD_LAST);

    always_ff @(posedge SC_FROGPOINT_CLOCK_50 or negedge SC_FROGPOINT_RESET_InLow) begin
        if (!SC_FROGPOINT_RESET_InLow) begin
            btn_s1  <= '1;
            btn_s2  <= '1;
            btn_s3  <= '1;
            state_q <= ST_PLAY;
            row_q   <= '0;
            col_q   <= SPAWN_COL;
            lives_q <= 2'(LIVES);
            nest_q  <= '0;
            hold_q  <= '0;
        end else begin
            btn_s1  <= btn_raw;
            btn_s2  <= btn_s1;
            btn_s3  <= btn_s2;
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            lives_q <= lives_d;
            nest_q  <= nest_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        lives_d = lives_q;
        nest_d  = nest_q;
        hold_d  = hold_q;
        case (state_q)
            ST_PLAY: begin
                if (SC_FROGPOINT_Lose_InHigh) begin
                    state_d = ST_HIT;
                    hold_d  = '0;
                    if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
                end else if (SC_FROGPOINT_Nest_InHigh && row_q == POS_MAX) begin
                    state_d = ST_NESTED;
                    hold_d  = '0;
                    if (nest_q != 4'hF) nest_d = nest_q + 4'd1;
                end else if (press[0]) begin
                    if (row_q != POS_MAX) row_d = row_q + CW'(1);
                end else if (press[1]) begin
                    if (row_q != '0) row_d = row_q - CW'(1);
                end else if (press[2]) begin
                    if (col_q != POS_MAX) col_d = col_q + CW'(1);
                end else if (press[3]) begin
                    if (col_q != '0) col_d = col_q - CW'(1);
                end
            end
            ST_HIT: begin
                if (hold_done) begin
                    if (lives_q == 2'd0) begin
                        state_d = ST_GAMEOVER;
                    end else begin
                        state_d = ST_PLAY;
                        row_d   = '0;
                        col_d   = SPAWN_COL;
                    end
                end else begin
                    hold_d = hold_q + HOLD_WIDTH'(1);
                end
            end
            ST_NESTED: begin
                if (hold_done) begin
                    state_d = ST_PLAY;
                    row_d   = '0;
                    col_d   = SPAWN_COL;
                end else begin
                    hold_d = hold_q + HOLD_WIDTH'(1);
                end
            end
            ST_GAMEOVER: ;
            default: state_d = ST_PLAY;
        endcase
    end

    logic [DATAWIDTH_BUS-1:0] rows [DATAWIDTH_BUS];

    always_comb begin
        for (int r = 0; r < DATAWIDTH_BUS; r++) begin
            rows[r] = '0;
            if (state_q != ST_GAMEOVER && row_q == CW'(r))
                rows[r] = DATAWIDTH_BUS'(1) << col_q;
        end
    end

    assign SC_FROGPOINT_POINTREG_0       = rows[0];
    assign SC_FROGPOINT_POINTREG_1       = rows[1];
    assign SC_FROGPOINT_POINTREG_2       = rows[2];
    assign SC_FROGPOINT_POINTREG_3       = rows[3];
    assign SC_FROGPOINT_POINTREG_4       = rows[4];
    assign SC_FROGPOINT_POINTREG_5       = rows[5];
    assign SC_FROGPOINT_POINTREG_6       = rows[6];
    assign SC_FROGPOINT_POINTREG_7       = rows[7];
    assign SC_FROGPOINT_Lives_Out        = (state_q == ST_GAMEOVER) ? 2'd0 : lives_q;
    assign SC_FROGPOINT_NestCount_Out    = nest_q;
    assign SC_FROGPOINT_GameOver_OutHigh = (state_q == ST_GAMEOVER);

endmodule

// File: tb/tb_sc_frog_pointreg.sv
// Directed bench for sc_frog_pointreg with a short hold (4 cycles) and hand-computed expectations.
module tb_sc_frog_pointreg;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic up = 1'b1, down = 1'b1, left = 1'b1, right = 1'b1;
    logic lose = 1'b0, nest = 1'b0;
    logic [7:0] p0, p1, p2, p3, p4, p5, p6, p7;
    logic [1:0] lives;
    logic [3:0] nest_cnt;
    logic       game_over;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    sc_frog_pointreg #(
        .DATAWIDTH_BUS(8), .START_COL(3), .LIVES(3), .HOLD_CYCLES(4), .HOLD_WIDTH(26)
    ) dut (
        .SC_FROGPOINT_CLOCK_50        (clk),
        .SC_FROGPOINT_RESET_InLow     (rst_n),
        .SC_FROGPOINT_Up_InLow        (up),
        .SC_FROGPOINT_Down_InLow      (down),
        .SC_FROGPOINT_Left_InLow      (left),
        .SC_FROGPOINT_Right_InLow     (right),
        .SC_FROGPOINT_Lose_InHigh     (lose),
        .SC_FROGPOINT_Nest_InHigh     (nest),
        .SC_FROGPOINT_POINTREG_0      (p0),
        .SC_FROGPOINT_POINTREG_1      (p1),
        .SC_FROGPOINT_POINTREG_2      (p2),
        .SC_FROGPOINT_POINTREG_3      (p3),
        .SC_FROGPOINT_POINTREG_4      (p4),
        .SC_FROGPOINT_POINTREG_5      (p5),
        .SC_FROGPOINT_POINTREG_6      (p6),
        .SC_FROGPOINT_POINTREG_7      (p7),
        .SC_FROGPOINT_Lives_Out       (lives),
        .SC_FROGPOINT_NestCount_Out   (nest_cnt),
        .SC_FROGPOINT_GameOver_OutHigh(game_over)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] frog_at(input int r, input int c);
        logic [63:0] m;
        m = '0;
        m[r*8 + c] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] board();
        return {p7, p6, p5, p4, p3, p2, p1, p0};
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: up = v;
            1: down = v;
            2: left = v;
            default: right = v;
        endcase
    endtask

    // 0=up 1=down 2=left 3=right; move lands on the 3rd edge, chain refilled on release
    task automatic press(input int b);
        set_btn(b, 1'b0);
        tick(3);
        set_btn(b, 1'b1);
        tick(3);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic pulse_lose();
        lose = 1'b1;
        tick(1);
        lose = 1'b0;
    endtask

    initial begin
        do_reset();
        check("reset_board", board(), frog_at(0, 3));
        check("reset_p0", 64'(p0), 64'h08);
        check("reset_lives", 64'(lives), 64'd3);
        check("reset_nest", 64'(nest_cnt), 64'd0);
        check("reset_go", 64'(game_over), 64'd0);

        // held Up: one move only, on the 3rd edge
        up = 1'b0;
        tick(2);
        check("up_before_3rd_edge", board(), frog_at(0, 3));
        tick(1);
        check("up_3rd_edge_p1", 64'(p1), 64'h08);
        check("up_3rd_edge_p0", 64'(p0), 64'h00);
        tick(7);
        check("up_held_no_repeat", board(), frog_at(1, 3));
        up = 1'b1;
        tick(3);

        press(1);
        check("down_to_row0", board(), frog_at(0, 3));
        press(1);
        check("down_sat_row0", board(), frog_at(0, 3));

        for (int i = 0; i < 4; i++) press(3);
        check("right_to_col0", board(), frog_at(0, 0));
        press(3);
        check("right_sat_col0", 64'(p0), 64'h01);
        for (int i = 0; i < 8; i++) press(2);
        check("left_sat_col7", 64'(p0), 64'h80);

        // Up and Left in the same cycle: Up wins, Left discarded
        do_reset();
        up = 1'b0;
        left = 1'b0;
        tick(3);
        up = 1'b1;
        left = 1'b1;
        tick(3);
        check("prio_up_over_left", board(), frog_at(1, 3));

        pulse_lose();
        check("hit1_lives", 64'(lives), 64'd2);
        check("hit1_frozen", board(), frog_at(1, 3));
        up = 1'b0;
        tick(2);
        up = 1'b1;
        check("hit1_held_btn_ignored", board(), frog_at(1, 3));
        tick(1);
        check("hit1_last_hold_cycle", board(), frog_at(1, 3));
        tick(1);
        check("hit1_respawn", board(), frog_at(0, 3));
        tick(2);
        check("hit1_no_late_move", board(), frog_at(0, 3));

        press(0);
        pulse_lose();
        check("hit2_lives", 64'(lives), 64'd1);
        tick(4);
        check("hit2_respawn", board(), frog_at(0, 3));

        pulse_lose();
        check("hit3_lives", 64'(lives), 64'd0);
        check("hit3_go_not_yet", 64'(game_over), 64'd0);
        tick(4);
        check("gameover_flag", 64'(game_over), 64'd1);
        check("gameover_board", board(), 64'd0);
        check("gameover_lives", 64'(lives), 64'd0);
        press(0);
        press(2);
        check("gameover_btn_ignored", board(), 64'd0);
        check("gameover_sticky", 64'(game_over), 64'd1);

        do_reset();
        check("after_go_reset", board(), frog_at(0, 3));
        for (int i = 0; i < 5; i++) press(0);
        nest = 1'b1;
        tick(1);
        nest = 1'b0;
        tick(1);
        check("nest_row5_ignored_cnt", 64'(nest_cnt), 64'd0);
        check("nest_row5_ignored_pos", board(), frog_at(5, 3));
        press(0);
        press(0);
        press(0);
        check("climb_sat_row7", 64'(p7), 64'h08);
        nest = 1'b1;
        tick(1);
        nest = 1'b0;
        check("nest_count1", 64'(nest_cnt), 64'd1);
        tick(3);
        check("nest_held_row7", board(), frog_at(7, 3));
        tick(1);
        check("nest_respawn", board(), frog_at(0, 3));
        check("nest_lives_kept", 64'(lives), 64'd3);

        // Lose beats Nest, then async reset mid-hold
        for (int i = 0; i < 7; i++) press(0);
        lose = 1'b1;
        nest = 1'b1;
        tick(1);
        lose = 1'b0;
        nest = 1'b0;
        check("lose_nest_lives", 64'(lives), 64'd2);
        check("lose_nest_cnt", 64'(nest_cnt), 64'd1);
        check("lose_nest_frozen", board(), frog_at(7, 3));
        tick(2);
        rst_n = 1'b0;
        #2;
        check("async_rst_board", board(), frog_at(0, 3));
        check("async_rst_lives", 64'(lives), 64'd3);
        check("async_rst_nest", 64'(nest_cnt), 64'd0);
        tick(1);
        rst_n = 1'b1;
        tick(6);
        check("post_rst_stable", board(), frog_at(0, 3));
        check("post_rst_go", 64'(game_over), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sc_frog_pointreg.md
Name: sc_frog_pointreg

Overview:
- Generates the frog-position bitmap rows that the board comparator checks against the car background on the 8x8 matrix.
- Turns debounced, active-low direction buttons into single-step moves.
- Reacts to the comparator's lose and nest flags: freezes the frog, respawns it, counts lives and nests, and declares game over.
- Sits between the button front-end and the comparator; outputs feed the comparator's point-register inputs and the display mux.

Parameters:
- DATAWIDTH_BUS, 8, row width and number of rows (fixed at 8).
- START_COL, 3, spawn column (bit index within the row).
- LIVES, 3, lives loaded at reset (1..3).
- HOLD_CYCLES, 50000000, freeze duration after a hit or a nest.
- HOLD_WIDTH, 26, hold counter width (must hold HOLD_CYCLES).

Ports:
- SC_FROGPOINT_CLOCK_50  in  1  system clock, rising edge.
- SC_FROGPOINT_RESET_InLow  in  1  asynchronous active-low reset.
- SC_FROGPOINT_Up_InLow  in  1  up button, active-low, level.
- SC_FROGPOINT_Down_InLow  in  1  down button, active-low.
- SC_FROGPOINT_Left_InLow  in  1  left button, active-low.
- SC_FROGPOINT_Right_InLow  in  1  right button, active-low.
- SC_FROGPOINT_Lose_InHigh  in  1  collision flag from comparator.
- SC_FROGPOINT_Nest_InHigh  in  1  nested flag from comparator.
- SC_FROGPOINT_POINTREG_0..7  out  8 each  frog bitmap rows; row 0 is the start row, row 7 is the nest row.
- SC_FROGPOINT_Lives_Out  out  2  remaining lives.
- SC_FROGPOINT_NestCount_Out  out  4  nests achieved, saturating.
- SC_FROGPOINT_GameOver_OutHigh  out  1  game over.

Behaviour:
- One clock; reset is asynchronous and active-low. All state is updated on the rising edge of SC_FROGPOINT_CLOCK_50.
- Reset values:
  - state PLAY, row 0, col START_COL;
  - lives LIVES, nest count 0, hold counter 0;
  - button synchronizer flops all 1.
  - Resulting outputs: POINTREG_0 = 1<<START_COL (8'b00001000); rows 1..7 = 0; Lives = LIVES; NestCount = 0; GameOver = 0.
- Button input path, per button:
  - chain s1 <= btn, s2 <= s1, s3 <= s2;
  - press = ~s2 & s3, so exactly one press per high-to-low transition;
  - a held button produces no repeats.
  - Latency: position changes on the 3rd rising edge after the button is first sampled low.
- Row decode is combinational from the registered row and col: POINTREG_r = (r == row) ? (8'b1 << col) : 8'b0. Exactly one bit is set across all rows, except in GAMEOVER.
- Moves (PLAY state only), one move per cycle, priority Up > Down > Left > Right. Lower-priority presses in the same cycle are discarded.
  - Up: row+1, saturates at 7.
  - Down: row-1, saturates at 0.
  - Left: col+1 (toward bit 7), saturates at 7.
  - Right: col-1, saturates at 0.
  - At a saturation boundary the press is consumed with no change.
- State machine: PLAY, HIT, NESTED, GAMEOVER.
  - PLAY, Lose=1: go to HIT; lives decrements (floors at 0); hold counter cleared; any move in that cycle is ignored.
  - PLAY, Lose=0, Nest=1, row==7: go to NESTED; NestCount+1, saturates at 15; hold counter cleared.
  - Lose has priority over Nest in the same cycle.
  - Nest=1 with row!=7 is ignored.
  - HIT: frog stays shown at the collision position; button presses are ignored; the counter increments each cycle. When counter == HOLD_CYCLES-1:
    - lives==0: go to GAMEOVER;
    - otherwise: row=0, col=START_COL, go to PLAY.
  - NESTED: frog stays shown in row 7; buttons are ignored. When counter == HOLD_CYCLES-1: row=0, col=START_COL, go to PLAY.
  - GAMEOVER: all POINTREG rows 0; GameOver=1; Lives=0; only reset leaves this state.
- Lose and Nest are level inputs sampled each cycle. They are used only in PLAY; their values in HIT and NESTED are ignored.
- Reset asserted mid-hold or mid-move returns immediately to the reset values; there is no pending-press carry-over.

Test Plan (HOLD_CYCLES=4, START_COL=3, LIVES=3):
- Reset, then press Up once and hold it low for 10 cycles -> POINTREG_1 = 8'h08 appears on the 3rd edge; exactly one move occurs; POINTREG_0 = 0.
- Press Right 4 times (col 3 -> 0), then once more, then Left 8 times -> column stays 0 after the 4th Right; the final column is 7 (POINTREG_0 = 8'h80) and saturates.
- Assert Up and Left presses in the same cycle -> only the row increments; col stays 3.
- Pulse Lose in row 1 -> Lives 3->2; frog held at row 1 for 4 cycles; then POINTREG_0 = 8'h08 and state PLAY. Repeat twice more -> Lives=0, GameOver=1, all rows 0; buttons have no effect until reset.
- Climb to row 7 and assert Nest -> NestCount=1; row 7 held 4 cycles; then respawn at row 0 col 3. Nest asserted at row 5 -> no change.
- Assert Lose and Nest together at row 7 -> HIT taken; Lives decrements; NestCount unchanged. Assert reset mid-hold -> reset values restored asynchronously.
